ram_responder: RTL and testbench

- Synthesizable single-port RAM target that sits at the far end of the RAM request interface, i.e. the responder that answers the test-bench driver/initiator.
- Accepts one request per cycle through a valid/ready handshake.
- Returns read data after a fixed, parameterised pipeline latency, with response back-pressure absorbed by an internal response FIFO.
- Writes complete silently.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_rsp_fifo.sv | 81 ++++++++
 rtl/ram_rsp_fifo_chk.sv | 13 +
 rtl/ram_responder.sv | 126 ++++++++++++
 tb/tb_ram_responder.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared constants and response payload type for the RAM responder and its bench.
package ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 16;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous response FIFO with wrap-around pointers; head is read straight
// from storage so it holds steady until popped.
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int FDEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  rsp_t push_data_i,
  input  logic pop_i,
  output rsp_t pop_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CNT_W = $clog2(FDEPTH + 1);

  rsp_t             mem_q [FDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FDEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_o     = (cnt_q == CNT_W'(FDEPTH));
  assign empty_o    = (cnt_q == CNT_W'(0));
  assign do_push_s  = push_i && !full_o;
  assign do_pop_s   = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ram_rsp_fifo_chk.sv
// Property checker: the outstanding-count throttle must keep the response
// FIFO from ever receiving a push while full.
module ram_rsp_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic full_i
);

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i))
    else $error("ram_rsp_fifo push while full");

endmodule

// File: rtl/ram_responder.sv
// Single-port RAM responder: valid/ready requests, fixed-latency read pipeline
// feeding a response FIFO, throttled by a count of outstanding reads.
module ram_responder #(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DEPTH      = ram_pkg::DEPTH,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  import ram_pkg::*;

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(RD_LATENCY + 2);
  localparam int FDEPTH = RD_LATENCY + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic                  accept_s, rd_acc_s, wr_acc_s, in_range_s, pop_s;
  logic [IDX_W-1:0]      idx_s;
  rsp_t                  rd_entry_s, push_data_s, head_s;
  logic                  push_s, fifo_full_s, fifo_empty_s;

  // Throttle on the registered count only, so rsp_ready never reaches req_ready.
  assign req_ready  = !rst && (outst_q < CNT_W'(RD_LATENCY + 1));
  assign accept_s   = req_valid && req_ready;
  assign rd_acc_s   = accept_s && !req_we;
  assign wr_acc_s   = accept_s && req_we;
  assign in_range_s = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx_s      = req_addr[IDX_W-1:0];

  assign rd_entry_s.err  = !in_range_s;
  assign rd_entry_s.data = in_range_s ? mem_q[idx_s] : {DATA_WIDTH{1'b0}};

  // Memory is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_acc_s && in_range_s) begin
      mem_q[idx_s] <= req_wdata;
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign push_s      = rd_acc_s;
      assign push_data_s = rd_entry_s;
    end else begin : g_latn
      logic [RD_LATENCY-2:0] stage_vld_q;
      rsp_t                  stage_q [RD_LATENCY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          stage_vld_q <= {(RD_LATENCY - 1){1'b0}};
        end else begin
          stage_vld_q[0] <= rd_acc_s;
          for (int k = 1; k < RD_LATENCY - 1; k++) begin
            stage_vld_q[k] <= stage_vld_q[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        stage_q[0] <= rd_entry_s;
        for (int k = 1; k < RD_LATENCY - 1; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end

      assign push_s      = stage_vld_q[RD_LATENCY-2];
      assign push_data_s = stage_q[RD_LATENCY-2];
    end
  endgenerate

  ram_rsp_fifo #(
    .FDEPTH(FDEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push_s),
    .push_data_i(push_data_s),
    .pop_i      (pop_s),
    .pop_data_o (head_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s)
  );

  ram_rsp_fifo_chk u_fifo_chk (
    .clk_i (clk),
    .rst_i (rst),
    .push_i(push_s),
    .full_i(fifo_full_s)
  );

  assign rsp_valid = !rst && !fifo_empty_s;
  assign rsp_rdata = rsp_valid ? head_s.data : {DATA_WIDTH{1'b0}};
  assign rsp_err   = rsp_valid ? head_s.err : 1'b0;
  assign pop_s     = rsp_valid && rsp_ready;

  always_comb begin
    outst_d = outst_q;
    case ({rd_acc_s, pop_s})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= {CNT_W{1'b0}};
    end else begin
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed scenarios plus a randomized
// run compared against a queue-based model of the responder's behaviour.
module tb_ram_responder;

  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int DEP = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  ram_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEP),
    .RD_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            rdy_at;
  } exp_t;

  int            tests = 0;
  int            fails = 0;
  int            now = 0;
  exp_t          mq[$];
  logic [DW-1:0] mem_m [DEP];
  logic [DW-1:0] got_d[$];
  logic          got_e[$];

  logic          obs_ready, obs_valid, obs_err;
  logic [DW-1:0] obs_rdata;
  logic          exp_ready, exp_valid, exp_err;
  logic [DW-1:0] exp_rdata;

  // One cycle: apply inputs, sample outputs, predict, advance the model.
  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic rr, input logic r);
    bit   acc;
    bit   pop;
    exp_t e;
    @(negedge clk);
    rst = r; req_valid = v; req_we = we; req_addr = a; req_wdata = wd; rsp_ready = rr;
    #1;
    obs_ready = req_ready; obs_valid = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err;
    exp_ready = !r && (mq.size() < LAT + 1);
    exp_valid = !r && (mq.size() > 0) && (mq[0].rdy_at <= now);
    exp_rdata = exp_valid ? mq[0].data : '0;
    exp_err   = exp_valid ? mq[0].err : 1'b0;
    if (obs_valid && rr) begin
      got_d.push_back(obs_rdata);
      got_e.push_back(obs_err);
    end
    acc = v && exp_ready;
    pop = exp_valid && rr;
    @(posedge clk);
    now++;
    if (r) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && we && a < DEP) begin
        mem_m[a[3:0]] = wd;
      end else if (acc && !we) begin
        e.data   = (a < DEP) ? mem_m[a[3:0]] : '0;
        e.err    = (a >= DEP);
        e.rdy_at = now + LAT - 1;
        mq.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1);
      tests++;
      if (obs_ready !== 1'b0 || obs_valid !== 1'b0 || obs_rdata !== 8'd0 || obs_err !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, want 0/0/00/0",
                 obs_ready, obs_valid, obs_rdata, obs_err);
      end
    end
    drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (obs_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", obs_ready);
    end
  endtask

  task automatic test_basic_read();
    drive(1'b1, 1'b1, 5'd3, 8'hA5, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (obs_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_early_valid: got %b want 0", obs_valid);
    end
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (obs_valid !== 1'b1 || obs_rdata !== 8'hA5 || obs_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_read: got valid=%b rdata=%h err=%b, want 1/a5/0", obs_valid, obs_rdata, obs_err);
    end
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (obs_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_single_rsp: got valid=%b want 0", obs_valid);
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 5'(i), 8'(i), 1'b1, 1'b0);
    got_d.delete(); got_e.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 5'(i), 8'd0, 1'b1, 1'b0);
      if (obs_ready !== 1'b1) drops++;
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (drops != 0 || got_d.size() != 16) begin
      fails++;
      $display("FAIL b2b_flow: got ready_drops=%0d responses=%0d, want 0/16", drops, got_d.size());
    end
    for (int i = 0; i < got_d.size(); i++) begin
      tests++;
      if (got_d[i] !== 8'(i) || got_e[i] !== 1'b0) begin
        fails++;
        $display("FAIL b2b_data[%0d]: got %h err=%b want %h err=0", i, got_d[i], got_e[i], 8'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    int            acc = 0;
    bit            seen = 0;
    logic [DW-1:0] head = '0;
    got_d.delete(); got_e.delete();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 5'(k + 1), 8'd0, 1'b0, 1'b0);
      if (obs_ready === 1'b1) acc++;
      tests++;
      if (obs_ready !== (k < 3)) begin
        fails++;
        $display("FAIL bp_ready[%0d]: got %b want %b", k, obs_ready, (k < 3));
      end
      if (obs_valid === 1'b1 && !seen) begin
        seen = 1; head = obs_rdata;
      end else if (seen) begin
        tests++;
        if (obs_valid !== 1'b1 || obs_rdata !== head) begin
          fails++;
          $display("FAIL bp_head_stable[%0d]: got valid=%b rdata=%h want 1/%h", k, obs_valid, obs_rdata, head);
        end
      end
    end
    tests++;
    if (acc != 3 || head !== 8'd1) begin
      fails++;
      $display("FAIL bp_accepts: got accepts=%0d head=%h want 3/01", acc, head);
    end
    drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_first_pop: got ready=%b valid=%b want 0/1", obs_ready, obs_valid);
    end
    drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (obs_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready_return: got %b want 1", obs_ready);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (got_d.size() != 3 || got_d[0] !== 8'd1 || got_d[1] !== 8'd2 || got_d[2] !== 8'd3) begin
      fails++;
      $display("FAIL bp_drain: got %0d rsps first=%h, want 3 rsps 01 02 03", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 8'hxx);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 5'd20, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (obs_valid !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 8'd0) begin
      fails++;
      $display("FAIL oob_read: got valid=%b err=%b rdata=%h want 1/1/00", obs_valid, obs_err, obs_rdata);
    end
    got_d.delete(); got_e.delete();
    drive(1'b1, 1'b1, 5'd20, 8'hFF, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd4, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (got_d.size() != 1 || got_d[0] !== 8'd4 || got_e[0] !== 1'b0) begin
      fails++;
      $display("FAIL oob_write_dropped: got %0d rsps data=%h want 1 rsp data=04", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 8'hxx);
    end
  endtask

  task automatic test_rw_hazard();
    drive(1'b1, 1'b1, 5'd5, 8'h11, 1'b1, 1'b0);
    got_d.delete(); got_e.delete();
    drive(1'b1, 1'b0, 5'd5, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd5, 8'h22, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd5, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (got_d.size() != 2 || got_d[0] !== 8'h11 || got_d[1] !== 8'h22) begin
      fails++;
      $display("FAIL rw_hazard: got %0d rsps first=%h, want 11 then 22", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_midflight();
    int stray = 0;
    drive(1'b1, 1'b1, 5'd7, 8'h5A, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd2, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1);
    tests++;
    if (obs_ready !== 1'b0 || obs_valid !== 1'b0 || obs_rdata !== 8'd0) begin
      fails++;
      $display("FAIL midrst_outputs: got ready=%b valid=%b rdata=%h want 0/0/00", obs_ready, obs_valid, obs_rdata);
    end
    drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (obs_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_ready: got %b want 1", obs_ready);
    end
    if (obs_valid !== 1'b0) stray++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
      if (obs_valid !== 1'b0) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL midrst_dropped: got %0d stray rsp cycles want 0", stray);
    end
    got_d.delete(); got_e.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 5'd7, 8'd0, 1'b0, 1'b0);
      tests++;
      if (obs_ready !== 1'b1) begin
        fails++;
        $display("FAIL midrst_count_clear[%0d]: got ready=%b want 1", i, obs_ready);
      end
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    tests++;
    if (got_d.size() != 3 || got_d[0] !== 8'h5A || got_d[2] !== 8'h5A) begin
      fails++;
      $display("FAIL midrst_retained: got %0d rsps first=%h want 3 rsps of 5a", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 79) == 0));
      tests++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        fails++;
        $display("FAIL rnd_flow[%0d]: got ready=%b valid=%b want %b/%b", c, obs_ready, obs_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        tests++;
        if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
          fails++;
          $display("FAIL rnd_data[%0d]: got %h err=%b want %h err=%b", c, obs_rdata, obs_err, exp_rdata, exp_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_rw_hazard();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
